// File: rtl/tff_seq_ctrl_if.sv
// Bundles the sequencer's control, feedback and status signals into one
// interface. The controller uses the slave view and the driving
// environment uses the master view.
interface tff_seq_ctrl_if;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [3:0] len;
    logic       q_in;
    logic       qb_in;
    logic       t;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] mism_cnt;
    logic [3:0] step;
    logic       exp_q;

    modport master (
        output start, abort, pattern, len, q_in, qb_in,
        input  t, busy, done, err, mism_cnt, step, exp_q
    );

    modport slave (
        input  start, abort, pattern, len, q_in, qb_in,
        output t, busy, done, err, mism_cnt, step, exp_q
    );
endinterface

// File: rtl/tff_seq_ctrl.sv
// Toggle-sequence controller for an external T flip-flop.
// The controller latches a pattern and a step count, then drives T one
// pattern bit per cycle. It tracks the q value the flip-flop should hold and
// compares that value against the q/qb feedback after each toggle. Mismatches
// set a sticky error flag and increment a saturating counter.
module tff_seq_ctrl (
    input  logic           clk,
    input  logic           rst,
    tff_seq_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state;
    logic [7:0] pattern_r;
    logic [3:0] len_r;
    logic [3:0] step_r;
    logic       exp_q_r;
    logic       err_r;
    logic [3:0] mism_r;
    logic       busy_r;
    logic       done_r;

    logic [3:0] len_eff;
    logic       t_bit;
    logic       mismatch;
    logic       last_step;
    logic [3:0] mism_next;

    // Decode the requested length, the current pattern bit, the feedback check,
    // the final-step condition and the saturated counter increment.
    always_comb begin
        len_eff   = (bus.len > 4'd8) ? 4'd8 : bus.len;
        t_bit     = pattern_r[step_r[2:0]];
        mismatch  = (bus.q_in != exp_q_r) || (bus.qb_in != ~bus.q_in);
        last_step = (step_r == (len_r - 4'd1));
        mism_next = (mism_r == 4'hF) ? mism_r : (mism_r + 4'd1);
    end

    // Sequencer: accept, baseline capture, per-step toggle and compare, final
    // compare, and a one-cycle completion pulse. Abort returns to IDLE at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pattern_r <= 8'd0;
            len_r     <= 4'd0;
            step_r    <= 4'd0;
            exp_q_r   <= 1'b0;
            err_r     <= 1'b0;
            mism_r    <= 4'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    if (bus.start) begin
                        err_r  <= 1'b0;
                        mism_r <= 4'd0;
                        if (len_eff != 4'd0) begin
                            pattern_r <= bus.pattern;
                            len_r     <= len_eff;
                            step_r    <= 4'd0;
                            state     <= INIT;
                            busy_r    <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end
                    end
                end

                INIT: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        exp_q_r <= bus.q_in;
                        state   <= RUN;
                    end
                end

                RUN: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        exp_q_r <= exp_q_r ^ t_bit;
                        step_r  <= step_r + 4'd1;
                        if ((step_r != 4'd0) && mismatch) begin
                            err_r  <= 1'b1;
                            mism_r <= mism_next;
                        end
                        if (last_step) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            err_r  <= 1'b1;
                            mism_r <= mism_next;
                        end
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end

                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    // T is asserted only while stepping. Drive the remaining status outputs
    // from their registers.
    always_comb begin
        bus.t        = (state == RUN) && t_bit;
        bus.busy     = busy_r;
        bus.done     = done_r;
        bus.err      = err_r;
        bus.mism_cnt = mism_r;
        bus.step     = step_r;
        bus.exp_q    = exp_q_r;
    end

endmodule
